// File: rtl/amplia_imagem_2x2_if.sv
// rtl/amplia_imagem_2x2_if.sv - pixel stream bundle for the 2x upscaler
interface amplia_imagem_2x2_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix;
    logic             sof;
    logic             eol;
    logic             eof;
    logic             valid;
    logic             ready;

    modport master (output pix, sof, eol, eof, valid, input ready);
    modport slave  (input pix, sof, eol, eof, valid, output ready);
endinterface

// File: rtl/amplia_imagem_2x2.sv
// rtl/amplia_imagem_2x2.sv - streaming 2x2 pixel-replication upscaler
// Even output rows consume input; odd output rows replay the one-line buffer.
module amplia_imagem_2x2 #(
    parameter int PIX_W = 8,
    parameter int IN_W  = 4,
    parameter int IN_H  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    amplia_imagem_2x2_if.slave  in_s,
    amplia_imagem_2x2_if.master out_s,
    output logic                frame_done,
    output logic                err_sync
);
    localparam int OW  = 2 * IN_W;
    localparam int OH  = 2 * IN_H;
    localparam int CW  = $clog2(IN_W);
    localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int OCW = $clog2(OW);
    localparam int ORW = $clog2(OH);

    typedef enum logic {ROW_A, ROW_B} state_t;

    state_t           state_q;
    logic             copy_q;
    logic             out_valid_q;
    logic [PIX_W-1:0] out_pix_q;
    logic [CW-1:0]    icol_q;
    logic [RW-1:0]    irow_q;
    logic [OCW-1:0]   ocol_q;
    logic [ORW-1:0]   orow_q;
    logic             frame_done_q;
    logic             err_sync_q;
    logic [PIX_W-1:0] buf_q [IN_W];

    logic          last_ocol, last_orow, last_icol, last_irow;
    logic          in_ready, in_fire, out_fire, sof_err;
    logic [CW-1:0] rep_idx, wr_idx;

    assign last_ocol = (ocol_q == OCW'(OW - 1));
    assign last_orow = (orow_q == ORW'(OH - 1));
    assign last_icol = (icol_q == CW'(IN_W - 1));
    assign last_irow = (irow_q == RW'(IN_H - 1));

    // The last copy of a row hands over to the replay row, so no pixel may be taken then.
    assign in_ready = (state_q == ROW_A) &&
                      (!out_valid_q || (out_s.ready && copy_q && !last_ocol));
    assign in_fire  = in_s.valid && in_ready;
    assign out_fire = out_valid_q && out_s.ready;
    assign sof_err  = in_fire && in_s.sof && ((irow_q != '0) || (icol_q != '0));
    assign rep_idx  = ocol_q[OCW-1:1] + CW'(1);
    assign wr_idx   = sof_err ? '0 : icol_q;

    assign in_s.ready  = in_ready;
    assign out_s.pix   = out_pix_q;
    assign out_s.valid = out_valid_q;
    assign out_s.sof   = (orow_q == '0) && (ocol_q == '0);
    assign out_s.eol   = last_ocol;
    assign out_s.eof   = last_ocol && last_orow;
    assign frame_done  = frame_done_q;
    assign err_sync    = err_sync_q;

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wr_idx] <= in_s.pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ROW_A;
            copy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pix_q    <= '0;
            icol_q       <= '0;
            irow_q       <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            frame_done_q <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            frame_done_q <= out_fire && last_ocol && last_orow;

            // Output counters track the position of the beat currently (or next) presented.
            if (out_fire) begin
                if (last_ocol) begin
                    ocol_q <= '0;
                    orow_q <= last_orow ? '0 : orow_q + ORW'(1);
                end else begin
                    ocol_q <= ocol_q + OCW'(1);
                end
            end

            case (state_q)
                ROW_A: begin
                    if (out_fire) begin
                        if (!copy_q) begin
                            copy_q <= 1'b1;
                        end else if (last_ocol) begin
                            state_q   <= ROW_B;
                            out_pix_q <= buf_q[0];
                            copy_q    <= 1'b0;
                        end else begin
                            out_valid_q <= 1'b0;
                            copy_q      <= 1'b0;
                        end
                    end
                    if (in_fire) begin
                        out_pix_q   <= in_s.pix;
                        out_valid_q <= 1'b1;
                        copy_q      <= 1'b0;
                        if (sof_err) begin
                            // Resynchronise: this pixel becomes (0,0) of a new frame.
                            err_sync_q <= 1'b1;
                            icol_q     <= CW'(1);
                            irow_q     <= '0;
                            ocol_q     <= '0;
                            orow_q     <= '0;
                        end else begin
                            icol_q <= last_icol ? '0 : icol_q + CW'(1);
                        end
                    end
                end
                ROW_B: begin
                    if (out_fire) begin
                        if (!copy_q) begin
                            copy_q <= 1'b1;
                        end else begin
                            copy_q <= 1'b0;
                            if (last_ocol) begin
                                state_q     <= ROW_A;
                                out_valid_q <= 1'b0;
                                irow_q      <= last_irow ? '0 : irow_q + RW'(1);
                            end else begin
                                out_pix_q <= buf_q[rep_idx];
                            end
                        end
                    end
                end
                default: state_q <= ROW_A;
            endcase
        end
    end
endmodule

// File: tb/tb_amplia_imagem_2x2.sv
// tb/tb_amplia_imagem_2x2.sv - scoreboard bench for the 2x upscaler
module tb_amplia_imagem_2x2;
    localparam int PIX_W = 8;
    localparam int IN_W  = 4;
    localparam int IN_H  = 2;
    localparam int OW    = 2 * IN_W;
    localparam int OH    = 2 * IN_H;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             sof;
        logic             eol;
        logic             eof;
        logic             rowb;
        logic             copy0;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done, err_sync;

    amplia_imagem_2x2_if #(.PIX_W(PIX_W)) in_if ();
    amplia_imagem_2x2_if #(.PIX_W(PIX_W)) out_if ();

    amplia_imagem_2x2 #(.PIX_W(PIX_W), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_s      (in_if),
        .out_s     (out_if),
        .frame_done(frame_done),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    beat_t            exp_q[$];
    logic [PIX_W-1:0] mbuf [IN_W];
    int  mcol = 0, mrow = 0;
    int  n_pass = 0, n_total = 0, n_fail = 0, n_beats = 0, cyc = 0;
    int  last_eof_cyc = -1;
    bit  toggle_mode = 1'b0, b2b_mode = 1'b0, fd_pend = 1'b0, stall_prev = 1'b0;
    logic [11:0] stall_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_beat(input logic [PIX_W-1:0] v, input int r, input int c);
        beat_t b;
        b.pix   = v;
        b.sof   = (r == 0) && (c == 0);
        b.eol   = (c == OW - 1);
        b.eof   = (r == OH - 1) && (c == OW - 1);
        b.rowb  = (r % 2) == 1;
        b.copy0 = (c % 2) == 0;
        exp_q.push_back(b);
    endtask

    task automatic model_pix(input logic [PIX_W-1:0] v, input bit sof);
        if (sof) begin
            mcol = 0;
            mrow = 0;
        end
        push_beat(v, 2 * mrow, 2 * mcol);
        push_beat(v, 2 * mrow, 2 * mcol + 1);
        mbuf[mcol] = v;
        if (mcol == IN_W - 1) begin
            for (int c = 0; c < OW; c++) push_beat(mbuf[c / 2], 2 * mrow + 1, c);
            mcol = 0;
            mrow = (mrow + 1) % IN_H;
        end else begin
            mcol++;
        end
    endtask

    task automatic send(input logic [PIX_W-1:0] v, input bit sof, input int gap);
        bit ok = 1'b0;
        int w = 0;
        model_pix(v, sof);
        in_if.pix   = v;
        in_if.sof   = sof;
        in_if.valid = 1'b1;
        while (!ok && w < 200) begin
            @(negedge clk);
            if (in_if.ready) ok = 1'b1;
            w++;
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        in_if.valid = 1'b0;
        in_if.sof   = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_if.ready = toggle_mode ? ~out_if.ready : 1'b1;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst_n) begin
            chk("frame_done", 32'(frame_done), 32'(fd_pend));
            fd_pend = 1'b0;
            if (stall_prev)
                chk("stall_hold", 32'({out_if.valid, out_if.pix, out_if.sof, out_if.eol, out_if.eof}),
                    32'(stall_val));
            if (exp_q.size() > 0) begin
                if (exp_q[0].rowb) chk("rowb_in_ready", 32'(in_if.ready), 32'd0);
                if (!out_if.valid) chk("idle_pos", 32'({exp_q[0].rowb, exp_q[0].copy0}), 32'b01);
            end
            stall_prev = out_if.valid && !out_if.ready;
            stall_val  = {1'b1, out_if.pix, out_if.sof, out_if.eol, out_if.eof};
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_pix", 32'(out_if.pix), 32'(e.pix));
                    chk("beat_sof", 32'(out_if.sof), 32'(e.sof));
                    chk("beat_eol", 32'(out_if.eol), 32'(e.eol));
                    chk("beat_eof", 32'(out_if.eof), 32'(e.eof));
                    n_beats++;
                    if (b2b_mode && e.sof && last_eof_cyc >= 0)
                        chk("b2b_gap", 32'(cyc - last_eof_cyc), 32'd2);
                    if (e.eof) begin
                        fd_pend      = 1'b1;
                        last_eof_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        in_if.pix   = '0;
        in_if.sof   = 1'b0;
        in_if.eol   = 1'b0;
        in_if.eof   = 1'b0;
        in_if.valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_out_pix", 32'(out_if.pix), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err_sync", 32'(err_sync), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd1);
        #1;
        rst_n = 1'b1;

        // continuous input, sink always ready
        n_beats = 0;
        for (int i = 0; i < 8; i++) send(8'((i + 1) * 10), 1'b0, 0);
        drain("t1_drain");
        chk("t1_beats", 32'(n_beats), 32'd32);

        // sink toggling ready every cycle
        n_beats = 0;
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(8'((i + 1) * 10), 1'b0, 0);
        drain("t2_drain");
        toggle_mode = 1'b0;
        chk("t2_beats", 32'(n_beats), 32'd32);

        // input gaps of 3 cycles
        n_beats = 0;
        for (int i = 0; i < 8; i++) send(8'((i + 1) * 10), 1'b0, 3);
        drain("t3_drain");
        chk("t3_beats", 32'(n_beats), 32'd32);

        // back-to-back frames
        n_beats = 0;
        last_eof_cyc = -1;
        b2b_mode = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i + 1), (i % 8) == 0, 0);
        drain("t6_drain");
        b2b_mode = 1'b0;
        chk("t6_beats", 32'(n_beats), 32'd64);
        chk("t6_err_sync", 32'(err_sync), 32'd0);

        // misplaced sof on the third pixel
        send(8'd10, 1'b0, 0);
        send(8'd20, 1'b0, 0);
        send(8'd99, 1'b1, 0);
        for (int i = 0; i < 7; i++) send(8'(41 + i), 1'b0, 0);
        drain("t4_drain");
        chk("t4_err_sync", 32'(err_sync), 32'd1);
        repeat (5) @(posedge clk);
        #2;
        chk("t4_err_sticky", 32'(err_sync), 32'd1);

        // reset in the middle of a replay row
        n_beats = 0;
        for (int i = 0; i < 4; i++) send(8'(200 + i), 1'b0, 0);
        begin
            int w = 0;
            while (n_beats < 10 && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("t5_reach_rowb", 32'(n_beats >= 10), 32'd1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("t5_rst_in_ready", 32'(in_if.ready), 32'd1);
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        fd_pend = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        n_beats = 0;
        for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0, 0);
        drain("t5_drain");
        chk("t5_beats", 32'(n_beats), 32'd32);
        chk("t5_err_sync", 32'(err_sync), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
